// File: rtl/ramcard_mem_bridge.sv
// rtl/ramcard_mem_bridge.sv - language-card RAM bridge: CPU bus cycles to req/ack memory transactions
// Optional RAMCARD_WRBUF_EN: one-deep posted write buffer with a one-entry pending read slot.
module ramcard_mem_bridge #(
    parameter int ADDR_W = 24
) (
    input  logic              clk,
    input  logic              reset_in,
    input  logic              cpu_strobe,
    input  logic              cpu_rnw,
    input  logic [7:0]        cpu_dout,
    input  logic [ADDR_W-1:0] ram_addr,
    input  logic              card_ram_we,
    input  logic              card_ram_rd,
    output logic [7:0]        card_din,
    output logic              data_valid,
    output logic              cpu_wait,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic              mem_ack,
    input  logic [7:0]        mem_rdata,
    output logic              err_overrun
);

`ifdef RAMCARD_WRBUF_EN
    typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_WPOST} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_RD, S_WR} state_t;
`endif

    state_t state;

    logic qual_rd;
    logic qual_wr;
    logic qual;
    logic ack;

    assign qual_rd = cpu_strobe & cpu_rnw & card_ram_rd;
    assign qual_wr = cpu_strobe & ~cpu_rnw & card_ram_we;
    assign qual    = qual_rd | qual_wr;
    // An acknowledge only counts while a request is actually on the port.
    assign ack     = mem_req & mem_ack;

`ifdef RAMCARD_WRBUF_EN
    logic              pend_valid;
    logic [ADDR_W-1:0] pend_addr;

    always_comb begin
        cpu_wait = 1'b0;
        case (state)
            S_IDLE:  cpu_wait = pend_valid | qual_rd;
            S_RD:    cpu_wait = 1'b1;
            S_WR:    cpu_wait = 1'b1;
            S_WPOST: cpu_wait = pend_valid | qual;
            default: cpu_wait = 1'b1;
        endcase
    end
`else
    always_comb begin
        cpu_wait = (state != S_IDLE) | qual;
    end
`endif

    always_ff @(posedge clk) begin
        if (reset_in) begin
            state       <= S_IDLE;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            card_din    <= '0;
            data_valid  <= 1'b0;
            err_overrun <= 1'b0;
`ifdef RAMCARD_WRBUF_EN
            pend_valid  <= 1'b0;
            pend_addr   <= '0;
`endif
        end else begin
            data_valid <= 1'b0;
            case (state)
                S_IDLE: begin
`ifdef RAMCARD_WRBUF_EN
                    // A read parked behind a posted write goes out before anything new.
                    if (pend_valid) begin
                        state      <= S_RD;
                        mem_req    <= 1'b1;
                        mem_we     <= 1'b0;
                        mem_addr   <= pend_addr;
                        pend_valid <= 1'b0;
                        if (qual) begin
                            err_overrun <= 1'b1;
                        end
                    end else
`endif
                    if (qual_rd) begin
                        state     <= S_RD;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_addr  <= ram_addr;
                        mem_wdata <= cpu_dout;
                    end else if (qual_wr) begin
`ifdef RAMCARD_WRBUF_EN
                        state     <= S_WPOST;
`else
                        state     <= S_WR;
`endif
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_addr  <= ram_addr;
                        mem_wdata <= cpu_dout;
                    end
                end
                S_RD: begin
                    if (qual) begin
                        err_overrun <= 1'b1;
                    end
                    if (ack) begin
                        state      <= S_IDLE;
                        mem_req    <= 1'b0;
                        card_din   <= mem_rdata;
                        data_valid <= 1'b1;
                    end
                end
                S_WR: begin
                    if (qual) begin
                        err_overrun <= 1'b1;
                    end
                    if (ack) begin
                        state   <= S_IDLE;
                        mem_req <= 1'b0;
                    end
                end
`ifdef RAMCARD_WRBUF_EN
                S_WPOST: begin
                    if (qual_rd && !pend_valid) begin
                        pend_valid <= 1'b1;
                        pend_addr  <= ram_addr;
                    end else if (qual) begin
                        err_overrun <= 1'b1;
                    end
                    if (ack) begin
                        state   <= S_IDLE;
                        mem_req <= 1'b0;
                    end
                end
`endif
                default: begin
                    state   <= S_IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule
